// File: rtl/ysyx_24100005_dmem_responder.sv
// Data-memory responder: valid/ready request channel, programmable latency, word array.
// Optional: define DMEM_MISALIGN_CHECK_EN to fault accesses with addr[1:0] != 0.
module ysyx_24100005_dmem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam logic [3:0]  LAT_C   = 4'(LATENCY);
  localparam logic [32:0] LIMIT_C = {1'b0, BASE} + (33'd4 << ADDR_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem [DEPTH];

  logic              exec_s;
  logic              do_write_s;
  logic              x_wen_s;
  logic [31:0]       x_addr_s;
  logic [31:0]       x_wdata_s;
  logic [3:0]        x_wmask_s;
  logic [31:0]       offset_s;
  logic [ADDR_W-1:0] idx_s;
  logic              fault_s;
  logic [31:0]       word_s;
  logic [31:0]       merged_s;
  logic              unused_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Execute-stage datapath: with zero latency the live request executes on its acceptance edge
  always_comb begin
    x_wen_s   = wen_q;
    x_addr_s  = addr_q;
    x_wdata_s = wdata_q;
    x_wmask_s = wmask_q;
    if (state_q == S_IDLE) begin
      x_wen_s   = req_wen;
      x_addr_s  = req_addr;
      x_wdata_s = req_wdata;
      x_wmask_s = req_wmask[3:0];
    end else begin
      x_wen_s   = wen_q;
      x_addr_s  = addr_q;
      x_wdata_s = wdata_q;
      x_wmask_s = wmask_q;
    end
    offset_s = x_addr_s - BASE;
    idx_s    = offset_s[ADDR_W+1:2];
    fault_s  = ({1'b0, x_addr_s} < {1'b0, BASE}) || ({1'b0, x_addr_s} >= LIMIT_C);
`ifdef DMEM_MISALIGN_CHECK_EN
    fault_s  = fault_s || (x_addr_s[1:0] != 2'b00);
`endif
    word_s   = mem[idx_s];
    merged_s = merge_bytes(word_s, x_wdata_s, x_wmask_s);
    unused_s = ^{offset_s[31:ADDR_W+2], offset_s[1:0], req_wmask[7:4]};
  end

  // Next-state, request latch and response generation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    exec_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask[3:0];
          cnt_d   = LAT_C;
          if (LAT_C == 4'd0) begin
            state_d = S_RESP;
            exec_s  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
          exec_s  = 1'b1;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (exec_s) begin
      if (fault_s) begin
        rdata_d = 32'd0;
        err_d   = 1'b1;
      end else if (x_wen_s) begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end else begin
        rdata_d = word_s;
        err_d   = 1'b0;
      end
    end else begin
      rdata_d = rdata_d;
    end
    do_write_s  = exec_s && !fault_s && x_wen_s && !rst;
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      wen_q       <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wmask_q     <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Word array: deliberately not reset so contents survive rst
  always_ff @(posedge clk) begin
    if (do_write_s) begin
      mem[idx_s] <= merged_s;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
